mpmc11_app_responder: RTL and testbench
=======================================

# mpmc11_app_responder

Responder model of the DDR controller application (app_*) interface, answering the command/write-data/read-data handshakes that the mpmc11 controller state machine drives. Accepts commands and write data with independent backpressure, commits writes to an internal word array, and returns read data in order after a fixed latency. Used as the memory-side endpoint in mpmc11 simulation and in FPGA self-test builds without external DRAM.

## Interface
- AWID, 10: word-index width; array holds 2**AWID words of DWID bits.
- DWID, 128: data width; mask width DWID/8.
- RD_LAT, 8: read latency pipeline stages, minimum 2.
- CMD_DEPTH, 4: command FIFO depth (power of 2).
- WDF_DEPTH, 4: write-data FIFO depth (power of 2).
- CALIB_CYCLES, 64: cycles from reset release to calib_complete.
- STALL_EN, 0: 1 enables pseudo-random app_rdy deassertion.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- calib_complete  out  1  calibration done.
- app_en  in  1  command valid.
- app_cmd  in  3  3'b000 write, 3'b001 read; all other values are unsupported.
- app_addr  in  29  byte address; word index = app_addr[AWID+2:3], app_addr[2:0] ignored.
- app_rdy  out  1  command accept.
- app_wdf_wren  in  1  write data valid.
- app_wdf_data  in  DWID  write data.
- app_wdf_mask  in  DWID/8  1 = byte NOT written.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren (single-beat data).
- app_wdf_rdy  out  1  write-data accept.
- app_rd_data  out  DWID  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- err  out  1  sticky: unsupported app_cmd retired, or app_wdf_end != app_wdf_wren.

## Operation
- States: CALIB, RUN. Reset enters CALIB and clears the counter. CALIB -> RUN when the counter reaches CALIB_CYCLES-1. RUN holds until reset.
- Command accepted on an edge where app_en && app_rdy; {cmd, index} pushed into the command FIFO.
- Write data accepted on an edge where app_wdf_wren && app_wdf_rdy; {data, mask} pushed into the WDF FIFO. Data may arrive before, with, or after its command.
- app_rdy = RUN && cmd_count < CMD_DEPTH && !stall. No same-cycle bypass on full.
- app_wdf_rdy = RUN && wdf_count < WDF_DEPTH.
- Retire logic handles at most one command per cycle, strictly in order, from the command FIFO head:
  - Write: retires only when the WDF FIFO is non-empty. Pops both FIFOs and writes unmasked bytes. If the WDF FIFO is empty, the head stalls and reads behind it wait.
  - Read: pops and reads the array into the latency pipe.
  - Other cmd: pops, sets err, no array access.
- Read after write to the same index returns the new data, because retire order is preserved.
- Stall: 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, advances every cycle in RUN. stall = STALL_EN && lfsr[3:0]==0.
- Reset mid-operation:
  - Flushes both FIFOs and the read pipe, clears err, restarts CALIB.
  - In-flight read data is discarded.
  - Array contents are retained.

## Timing
- Reset values:
  - calib_complete=0, app_rdy=0, app_wdf_rdy=0
  - app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, err=0
- calib_complete rises exactly CALIB_CYCLES cycles after the first edge with rst low.
- Read into an empty command FIFO accepted at edge k: retires at edge k+1, app_rd_data_valid high in the cycle after edge k+1+RD_LAT (RD_LAT+1 cycles from acceptance).
- Back-to-back reads: one valid beat per cycle, no gaps once streaming.
- Write accepted at edge k with data already queued: array updated at edge k+1.
- The FIFOs register the full/empty flags.

## Structure
- mpmc11_pkg: APP_CMD_WRITE, APP_CMD_READ constants; mpmc11_app_resp_state_t {CALIB, RUN}.
- Sub-module mpmc11_app_fifo: parameterised sync FIFO (width, depth) with count output. Instantiated twice, for commands and for write data.
- Array is inferred RAM with byte enables. The read pipe is a valid/data shift register.

## Test plan
- Reset, hold app_en=1 -> app_rdy=0 for 64 cycles, calib_complete and app_rdy rise together on cycle 64.
- Write addr 0x40 data 128'h0123…EF mask 0, then read 0x40 -> valid 9 cycles after read accept, data matches.
- Write addr 0x48 mask 16'hFFF0 over prior all-ones word with data 0 -> read returns low 4 bytes 0, rest 0xFF.
- Issue 4 write commands with no data -> 5th app_en sees app_rdy=0; queued read waits; supply 4 data beats -> all retire, read data correct.
- app_cmd=3'b010 -> err=1 sticky, no read beat; rst mid-read burst -> no valid beats after reset, err=0.
- STALL_EN=1, 1000 random reads/writes vs scoreboard -> in-order data matches, app_rdy low ~1/16 cycles.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - shared types and constants for the mpmc11 app-interface responder
package mpmc11_pkg;

  localparam logic [2:0]  APP_CMD_WRITE = 3'b000;
  localparam logic [2:0]  APP_CMD_READ  = 3'b001;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

  typedef enum logic {
    CALIB,
    RUN
  } mpmc11_app_resp_state_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/mpmc11_app_fifo.sv
// rtl/mpmc11_app_fifo.sv - synchronous FIFO with registered full/empty and occupancy count
module mpmc11_app_fifo
  import mpmc11_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Flags are registered from the next count so consumers see clean flops
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mpmc11_app_responder.sv
// rtl/mpmc11_app_responder.sv - memory-side responder for the mpmc11 DDR app_* interface
module mpmc11_app_responder
  import mpmc11_pkg::*;
#(
  parameter int AWID         = 10,
  parameter int DWID         = 128,
  parameter int RD_LAT       = 8,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_EN     = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                calib_complete,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [28:0]         app_addr,
  output logic                app_rdy,
  input  logic                app_wdf_wren,
  input  logic [DWID-1:0]     app_wdf_data,
  input  logic [DWID/8-1:0]   app_wdf_mask,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DWID-1:0]     app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                err
);

  localparam int MW   = DWID / 8;
  localparam int CMDW = 3 + AWID;
  localparam int WDFW = DWID + MW;
  localparam int CCW  = $clog2(CALIB_CYCLES + 1);

  mpmc11_app_resp_state_t state, state_nxt;
  logic [CCW-1:0]  calib_cnt;
  logic            run;
  logic [15:0]     lfsr;
  logic            stall;

  logic                        cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMDW-1:0]             cmd_head;
  logic [$clog2(CMD_DEPTH):0]  cmd_count;
  logic                        wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [WDFW-1:0]             wdf_head;
  logic [$clog2(WDF_DEPTH):0]  wdf_count;

  logic [2:0]      head_cmd;
  logic [AWID-1:0] head_idx;
  logic [DWID-1:0] wdf_data;
  logic [MW-1:0]   wdf_mask;
  logic            wr_issue, rd_issue, bad_issue;

  logic [DWID-1:0] mem [2**AWID];
  logic [DWID-1:0] pipe_data [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld;

  logic unused_ok;
  assign unused_ok = ^{app_addr[28:AWID+3], app_addr[2:0], cmd_count, wdf_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CALIB;
      calib_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CALIB) calib_cnt <= calib_cnt + CCW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CALIB:   if (calib_cnt == CCW'(CALIB_CYCLES - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CALIB;
    endcase
  end

  assign run            = (state == RUN);
  assign calib_complete = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (run) begin
      lfsr <= lfsr16_next(lfsr);
    end
  end

  assign stall       = (STALL_EN != 0) && (lfsr[3:0] == 4'h0);
  assign app_rdy     = run && !cmd_full && !stall;
  assign app_wdf_rdy = run && !wdf_full;
  assign cmd_push    = app_en && app_rdy;
  assign wdf_push    = app_wdf_wren && app_wdf_rdy;

  mpmc11_app_fifo #(.WIDTH(CMDW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .din   ({app_cmd, app_addr[AWID+2:3]}),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  mpmc11_app_fifo #(.WIDTH(WDFW), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wdf_push),
    .din   ({app_wdf_data, app_wdf_mask}),
    .pop   (wdf_pop),
    .dout  (wdf_head),
    .full  (wdf_full),
    .empty (wdf_empty),
    .count (wdf_count)
  );

  assign {head_cmd, head_idx} = cmd_head;
  assign {wdf_data, wdf_mask} = wdf_head;

  // A write at the head blocks everything behind it until its data beat is queued
  always_comb begin
    wr_issue  = 1'b0;
    rd_issue  = 1'b0;
    bad_issue = 1'b0;
    if (!cmd_empty) begin
      case (head_cmd)
        APP_CMD_WRITE: wr_issue  = !wdf_empty;
        APP_CMD_READ:  rd_issue  = 1'b1;
        default:       bad_issue = 1'b1;
      endcase
    end
  end

  assign cmd_pop = wr_issue || rd_issue || bad_issue;
  assign wdf_pop = wr_issue;

  always_ff @(posedge clk) begin
    if (wr_issue) begin
      for (int b = 0; b < MW; b++) begin
        if (!wdf_mask[b]) mem[head_idx][b*8 +: 8] <= wdf_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= mem[head_idx];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld          <= '0;
      app_rd_data_valid <= 1'b0;
      app_rd_data       <= '0;
    end else begin
      pipe_vld          <= {pipe_vld[RD_LAT-2:0], rd_issue};
      app_rd_data_valid <= pipe_vld[RD_LAT-1];
      app_rd_data       <= pipe_vld[RD_LAT-1] ? pipe_data[RD_LAT-1] : '0;
    end
  end

  assign app_rd_data_end = app_rd_data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bad_issue || (app_wdf_end != app_wdf_wren)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpmc11_app_responder.sv
// tb/tb_mpmc11_app_responder.sv - randomized self-checking bench for mpmc11_app_responder
module tb_mpmc11_app_responder;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int LAT = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         calib_complete;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [28:0]  app_addr;
  logic         app_rdy;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         err;

  always #5 clk = ~clk;

  mpmc11_app_responder #(.STALL_EN(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .calib_complete    (calib_complete),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_rdy           (app_rdy),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask      (app_wdf_mask),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .err               (err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [127:0] mdl_mem [1024];
  logic [127:0] exp_q [$];
  int           mcnt = 0;
  logic [15:0]  mlfsr = 16'hACE1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15-15] ^ s[16-14] ^ s[16-13] ^ s[16-11];
    return (s >> 1) | ({15'd0, fb} << 15);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference for calibration timing and the stall generator
  always @(posedge clk) begin
    if (rst) begin
      mcnt  <= 0;
      mlfsr <= 16'hACE1;
    end else if (mcnt >= 64) begin
      mlfsr <= lfsr_step(mlfsr);
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_spurious", app_rd_data_valid, 1'b0);
      end else begin
        check("rd_data", app_rd_data, exp_q.pop_front());
      end
      check("rd_end", app_rd_data_end, 1'b1);
    end
    if (mcnt >= 64 && mlfsr[3:0] == 4'h0) check("stall_rdy", app_rdy, 1'b0);
  end

  function automatic void mdl_write(input logic [9:0] idx, input logic [127:0] d, input logic [15:0] m);
    for (int b = 0; b < 16; b++) begin
      if (!m[b]) mdl_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  task automatic send_cmd(input logic [2:0] cmd, input logic [28:0] addr, output int acc);
    int n;
    n = 0;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    while (app_rdy !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("cmd_hs_timeout", app_rdy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    app_en = 1'b0;
  endtask

  task automatic send_wdf(input logic [127:0] d, input logic [15:0] m);
    int n;
    n = 0;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    while (app_wdf_rdy !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("wdf_hs_timeout", app_wdf_rdy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic do_write(input logic [28:0] addr, input logic [127:0] d, input logic [15:0] m,
                          input bit data_first);
    int k;
    mdl_write(addr[12:3], d, m);
    if (data_first) begin
      send_wdf(d, m);
      send_cmd(CMD_WR, addr, k);
    end else begin
      send_cmd(CMD_WR, addr, k);
      send_wdf(d, m);
    end
  endtask

  task automatic do_read(input logic [28:0] addr, output int acc);
    exp_q.push_back(mdl_mem[addr[12:3]]);
    send_cmd(CMD_RD, addr, acc);
  endtask

  task automatic wait_beat(input string tag, output logic [127:0] d, output int c);
    int n;
    n = 0;
    while (app_rd_data_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check({tag, "_timeout"}, app_rd_data_valid, 1'b1);
    d = app_rd_data;
    c = cyc;
    @(negedge clk);
  endtask

  task automatic wait_calib();
    int n;
    n = 0;
    while (calib_complete !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("calib_timeout", calib_complete, 1'b1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, kr, c, n;
    int acc [4];
    bit early;
    logic [127:0] d;
    logic [127:0] wd [4];
    logic [28:0] a;

    app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_calib", calib_complete, 1'b0);
    check("rst_rdy", app_rdy, 1'b0);
    check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
    check("rst_rd_valid", app_rd_data_valid, 1'b0);
    check("rst_rd_end", app_rd_data_end, 1'b0);
    check("rst_rd_data", app_rd_data, 128'd0);
    check("rst_err", err, 1'b0);

    // Calibration: app_en held high, nothing accepted until cycle 64
    app_en = 1'b1; app_cmd = CMD_RD; app_addr = '0;
    rst = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64 && (calib_complete || app_rdy)) early = 1'b1;
      if (i == 64) begin
        check("calib_rise", calib_complete, 1'b1);
        check("rdy_rise", app_rdy, 1'b1);
        app_en = 1'b0;
      end
    end
    check("calib_early", early, 1'b0);

    // Full write then read, with latency and constant data
    do_write(29'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    do_read(29'h40, k);
    wait_beat("lat", d, c);
    check("rd_latency", c - k, LAT);
    check("rd_0x40", d, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Partial mask over an all-ones word
    do_write(29'h48, {128{1'b1}}, 16'h0000, 1'b1);
    do_write(29'h48, 128'd0, 16'hFFF0, 1'b0);
    do_read(29'h48, k);
    wait_beat("mask", d, c);
    check("rd_mask", d, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

    // Back-to-back reads stream with fixed latency
    for (int i = 0; i < 4; i++) do_read((i % 2 == 0) ? 29'h40 : 29'h48, acc[i]);
    for (int i = 0; i < 4; i++) begin
      wait_beat("burst", d, c);
      check("burst_lat", c - acc[i], LAT);
    end

    // Four writes without data fill the command FIFO; a read behind them waits
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      mdl_write(10'd16 + 10'(i), wd[i], 16'h0000);
      send_cmd(CMD_WR, 29'h80 + 29'(8 * i), k);
    end
    check("cmd_full", app_rdy, 1'b0);
    fork
      do_read(29'h88, kr);
      begin
        repeat (4) @(negedge clk);
        check("full_hold", app_rdy, 1'b0);
        check("rd_blocked", app_rd_data_valid, 1'b0);
        for (int i = 0; i < 4; i++) send_wdf(wd[i], 16'h0000);
      end
    join
    wait_beat("queued", d, c);
    check("rd_queued", d, wd[1]);

    // Unsupported command: sticky err, no read beat
    send_cmd(3'b010, 29'h40, k);
    repeat (5) @(negedge clk);
    check("err_set", err, 1'b1);
    repeat (10) @(negedge clk);
    check("err_sticky", err, 1'b1);

    // Reset during a read burst discards in-flight data and clears err
    for (int i = 0; i < 4; i++) do_read(29'h40, k);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_calib", calib_complete, 1'b0);
    check("mid_rst_valid", app_rd_data_valid, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_calib", calib_complete, 1'b0);
    wait_calib();
    do_read(29'h48, k);
    wait_beat("retain", d, c);
    check("array_retained", d, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

    // Last-beat flag disagreeing with write-enable
    app_wdf_end = 1'b1;
    @(negedge clk);
    app_wdf_end = 1'b0;
    @(negedge clk);
    check("err_wdf_end", err, 1'b1);

    // Randomized traffic against the array model
    for (int i = 16; i < 32; i++) begin
      a = {16'($urandom), 10'(i), 3'($urandom)};
      do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 1'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      a = {16'($urandom), 10'(16 + $urandom_range(0, 15)), 3'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, k);
      end else begin
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'($urandom));
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
